execute_wb_stage: RTL and testbench

EXECUTE_WB_STAGE -- requirements
Module: execute_wb_stage

---
 rtl/execute_wb_stage.sv | 199 +++++++++++++++++++
 tb/tb_execute_wb_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_wb_stage
// Purpose  : Execute and write-back pipeline stages with load-use interlock
//            and an optional 2-cycle multiplier (define EXEC_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module execute_wb_stage #(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_read,
    input  logic [3:0]        opcode_read,
    input  logic [2:0]        dest_read,
    input  logic [D_SIZE-1:0] op1_read,
    input  logic [D_SIZE-1:0] op2_read,
    input  logic [2:0]        raddr_1,
    input  logic [2:0]        raddr_2,
    input  logic              flush,
    input  logic [D_SIZE-1:0] data_in,
    output logic              stall,
    output logic              reset_execute,
    output logic              flag_result_execute,
    output logic [2:0]        dest_execute,
    output logic [D_SIZE-1:0] comb_result_execute,
    output logic              reset_wb,
    output logic              write_en,
    output logic [2:0]        dest_wb,
    output logic [D_SIZE-1:0] result_wb,
    output logic [A_SIZE-1:0] addr,
    output logic [D_SIZE-1:0] data_out,
    output logic              read,
    output logic              write
);

    localparam int SH_W = $clog2(D_SIZE);

    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_SHRA  = 4'd8;
    localparam logic [3:0] OP_LOADC = 4'd9;
    localparam logic [3:0] OP_LOAD  = 4'd10;
    localparam logic [3:0] OP_STORE = 4'd11;

    logic              ex_valid_q, ex_valid_d;
    logic [3:0]        ex_op_q,    ex_op_d;
    logic [2:0]        ex_dest_q,  ex_dest_d;
    logic [D_SIZE-1:0] ex_op1_q,   ex_op1_d;
    logic [D_SIZE-1:0] ex_op2_q,   ex_op2_d;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_wr_q,    wb_wr_d;
    logic              wb_load_q,  wb_load_d;
    logic [2:0]        wb_dest_q,  wb_dest_d;
    logic [D_SIZE-1:0] wb_res_q,   wb_res_d;

    logic              w_mul_busy;
    logic              w_mul_done;
    logic              w_is_alu;
    logic              w_is_load;
    logic              w_writes;
    logic              w_load_use;
    logic [SH_W-1:0]   w_shamt;
    logic [D_SIZE-1:0] w_result;

`ifdef EXEC_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [0:0] MS_IDLE = 1'b0;
    localparam logic [0:0] MS_DONE = 1'b1;

    logic [0:0]          mul_state_q, mul_state_d;
    logic                w_ex_mul;
    logic [2*D_SIZE-1:0] w_prod;

    assign w_ex_mul = ex_valid_q && (ex_op_q == OP_MUL);
    assign w_prod   = {{D_SIZE{1'b0}}, ex_op1_q} * {{D_SIZE{1'b0}}, ex_op2_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mul_state_q <= MS_IDLE;
        else        mul_state_q <= mul_state_d;
    end

    always_comb begin
        mul_state_d = MS_IDLE;
        if (mul_state_q == MS_IDLE && w_ex_mul) mul_state_d = MS_DONE;
    end

    // First cycle of a MUL in execute is BUSY, the second one completes it.
    always_comb begin
        w_mul_busy = w_ex_mul && (mul_state_q == MS_IDLE);
        w_mul_done = w_ex_mul && (mul_state_q == MS_DONE);
    end
`else
    assign w_mul_busy = 1'b0;
    assign w_mul_done = 1'b0;
`endif

    assign w_shamt   = ex_op2_q[SH_W-1:0];
    assign w_is_alu  = (ex_op_q >= OP_ADD) && (ex_op_q <= OP_SHRA);
    assign w_is_load = (ex_op_q == OP_LOAD);
    assign w_writes  = w_is_alu || (ex_op_q == OP_LOADC) || w_is_load || w_mul_done;

    always_comb begin
        w_result = '0;
        case (ex_op_q)
            OP_ADD:   w_result = ex_op1_q + ex_op2_q;
            OP_SUB:   w_result = ex_op1_q - ex_op2_q;
            OP_AND:   w_result = ex_op1_q & ex_op2_q;
            OP_OR:    w_result = ex_op1_q | ex_op2_q;
            OP_XOR:   w_result = ex_op1_q ^ ex_op2_q;
            OP_SHL:   w_result = ex_op1_q << w_shamt;
            OP_SHR:   w_result = ex_op1_q >> w_shamt;
            OP_SHRA:  w_result = $signed(ex_op1_q) >>> w_shamt;
            OP_LOADC: w_result = ex_op2_q;
`ifdef EXEC_MUL_EN
            OP_MUL:   w_result = w_prod[D_SIZE-1:0];
`endif
            default:  w_result = '0;
        endcase
    end

    assign w_load_use = ex_valid_q && w_is_load && valid_read &&
                        ((ex_dest_q == raddr_1) || (ex_dest_q == raddr_2));

    // Flush beats the load-use stall, but never a multiply in progress.
    assign stall = w_mul_busy || (w_load_use && !flush);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_dest_d  = ex_dest_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        if (!w_mul_busy) begin
            ex_valid_d = valid_read && !flush && !w_load_use;
            ex_op_d    = opcode_read;
            ex_dest_d  = dest_read;
            ex_op1_d   = op1_read;
            ex_op2_d   = op2_read;
        end
    end

    always_comb begin
        wb_valid_d = ex_valid_q && !w_mul_busy;
        wb_wr_d    = ex_valid_q && !w_mul_busy && w_writes;
        wb_load_d  = ex_valid_q && w_is_load;
        wb_dest_d  = ex_dest_q;
        wb_res_d   = w_result;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_dest_q  <= '0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_wr_q    <= 1'b0;
            wb_load_q  <= 1'b0;
            wb_dest_q  <= '0;
            wb_res_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_dest_q  <= ex_dest_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            wb_valid_q <= wb_valid_d;
            wb_wr_q    <= wb_wr_d;
            wb_load_q  <= wb_load_d;
            wb_dest_q  <= wb_dest_d;
            wb_res_q   <= wb_res_d;
        end
    end

    assign reset_execute       = ex_valid_q;
    assign flag_result_execute = ex_valid_q && (w_is_alu || (ex_op_q == OP_LOADC) || w_mul_done);
    assign dest_execute        = ex_dest_q;
    assign comb_result_execute = w_result;
    assign addr                = ex_op1_q[A_SIZE-1:0];
    assign data_out            = ex_op2_q;
    assign read                = ex_valid_q && w_is_load;
    assign write               = ex_valid_q && (ex_op_q == OP_STORE);

    assign reset_wb  = wb_valid_q;
    assign write_en  = wb_wr_q;
    assign dest_wb   = wb_dest_q;
    assign result_wb = wb_load_q ? data_in : wb_res_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_wb_stage
// Purpose  : Directed self-checking bench for execute_wb_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_wb_stage;

    localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, XOR_ = 4'd5, SHL = 4'd6,
                           SHR = 4'd7, SHRA = 4'd8, LOADC = 4'd9, LOAD = 4'd10,
                           STORE = 4'd11, MUL = 4'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_read;
    logic [3:0]  opcode_read;
    logic [2:0]  dest_read;
    logic [31:0] op1_read, op2_read;
    logic [2:0]  raddr_1, raddr_2;
    logic        flush;
    logic [31:0] data_in;
    logic        stall, reset_execute, flag_result_execute;
    logic [2:0]  dest_execute;
    logic [31:0] comb_result_execute;
    logic        reset_wb, write_en;
    logic [2:0]  dest_wb;
    logic [31:0] result_wb;
    logic [9:0]  addr;
    logic [31:0] data_out;
    logic        read, write;

    int total  = 0;
    int passed = 0;

    execute_wb_stage #(.A_SIZE(10), .D_SIZE(32)) dut (
        .clk(clk), .reset(reset), .valid_read(valid_read), .opcode_read(opcode_read),
        .dest_read(dest_read), .op1_read(op1_read), .op2_read(op2_read),
        .raddr_1(raddr_1), .raddr_2(raddr_2), .flush(flush), .data_in(data_in),
        .stall(stall), .reset_execute(reset_execute),
        .flag_result_execute(flag_result_execute), .dest_execute(dest_execute),
        .comb_result_execute(comb_result_execute), .reset_wb(reset_wb),
        .write_en(write_en), .dest_wb(dest_wb), .result_wb(result_wb),
        .addr(addr), .data_out(data_out), .read(read), .write(write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [3:0] op, input logic [2:0] d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] r1, input logic [2:0] r2);
        valid_read  = v;
        opcode_read = op;
        dest_read   = d;
        op1_read    = a;
        op2_read    = b;
        raddr_1     = r1;
        raddr_2     = r2;
    endtask

    task automatic idle();
        drv(1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 3'd0, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        data_in = 32'd0;
        idle();
        #3;
        chk("rst_ex_valid", reset_execute, 0);
        chk("rst_wb_valid", reset_wb, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_stall", stall, 0);
        tick();
        reset = 1'b1;

        // ADD 5+7 -> 12
        drv(1'b1, ADD, 3'd3, 32'd5, 32'd7, 3'd0, 3'd0);
        tick();
        chk("add_result", comb_result_execute, 32'd12);
        chk("add_flag", flag_result_execute, 1);
        chk("add_dest_ex", dest_execute, 3);
        idle();
        tick();
        chk("add_write_en", write_en, 1);
        chk("add_dest_wb", dest_wb, 3);
        chk("add_result_wb", result_wb, 32'd12);
        chk("add_ex_empty", reset_execute, 0);

        // LOAD followed by dependent ADD
        drv(1'b1, LOAD, 3'd2, 32'h10, 32'd0, 3'd0, 3'd0);
        tick();
        chk("ld_read", read, 1);
        chk("ld_addr", addr, 32'h10);
        chk("ld_flag", flag_result_execute, 0);
        drv(1'b1, ADD, 3'd4, 32'd1, 32'd1, 3'd2, 3'd0);
        #1;
        chk("ld_use_stall", stall, 1);
        tick();
        data_in = 32'hAB;
        #1;
        chk("ld_bubble", reset_execute, 0);
        chk("ld_wb_we", write_en, 1);
        chk("ld_wb_dest", dest_wb, 2);
        chk("ld_wb_data", result_wb, 32'hAB);
        chk("ld_stall_clear", stall, 0);
        tick();
        chk("ld_add_enter", reset_execute, 1);
        chk("ld_add_result", comb_result_execute, 32'd2);
        chk("ld_wb_bubble", reset_wb, 0);
        idle();
        tick();
        chk("ld_add_wb", result_wb, 32'd2);

        // Shifts / SUB / XOR
        drv(1'b1, SHRA, 3'd1, 32'h8000_0000, 32'd4, 3'd0, 3'd0);
        tick();
        chk("shra", comb_result_execute, 32'hF800_0000);
        drv(1'b1, SHR, 3'd1, 32'h8000_0000, 32'd4, 3'd0, 3'd0);
        tick();
        chk("shr", comb_result_execute, 32'h0800_0000);
        drv(1'b1, SUB, 3'd1, 32'd0, 32'd1, 3'd0, 3'd0);
        tick();
        chk("sub_wrap", comb_result_execute, 32'hFFFF_FFFF);
        drv(1'b1, SHL, 3'd1, 32'd1, 32'h21, 3'd0, 3'd0);
        tick();
        chk("shl_amt_mod", comb_result_execute, 32'd2);
        drv(1'b1, XOR_, 3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0, 3'd0);
        tick();
        chk("xor", comb_result_execute, 32'h0FF0_0FF0);
        drv(1'b1, LOADC, 3'd1, 32'd9, 32'h1234, 3'd0, 3'd0);
        tick();
        chk("loadc", comb_result_execute, 32'h1234);
        chk("loadc_flag", flag_result_execute, 1);

        // STORE
        drv(1'b1, STORE, 3'd5, 32'h3FF, 32'h55, 3'd0, 3'd0);
        tick();
        chk("st_write", write, 1);
        chk("st_read", read, 0);
        chk("st_addr", addr, 32'h3FF);
        chk("st_data", data_out, 32'h55);
        chk("st_flag", flag_result_execute, 0);
        idle();
        tick();
        chk("st_wb_valid", reset_wb, 1);
        chk("st_no_we", write_en, 0);

        // Flush overrides load-use stall and does not cancel LOAD in execute
        drv(1'b1, LOAD, 3'd6, 32'h20, 32'd0, 3'd0, 3'd0);
        tick();
        drv(1'b1, ADD, 3'd4, 32'd1, 32'd1, 3'd6, 3'd0);
        flush = 1'b1;
        #1;
        chk("fl_no_stall", stall, 0);
        tick();
        flush = 1'b0;
        idle();
        chk("fl_bubble", reset_execute, 0);
        chk("fl_load_wb", write_en, 1);
        chk("fl_load_dest", dest_wb, 6);

        // MUL
        drv(1'b1, MUL, 3'd7, 32'd6, 32'd7, 3'd0, 3'd0);
        tick();
        idle();
        #1;
`ifdef EXEC_MUL_EN
        chk("mul_busy_stall", stall, 1);
        chk("mul_busy_flag", flag_result_execute, 0);
        tick();
        chk("mul_done_flag", flag_result_execute, 1);
        chk("mul_done_res", comb_result_execute, 32'd42);
        chk("mul_done_stall", stall, 0);
        chk("mul_wb_bubble", reset_wb, 0);
        tick();
        chk("mul_we", write_en, 1);
        chk("mul_wb_res", result_wb, 32'd42);
        chk("mul_wb_dest", dest_wb, 7);
`else
        chk("mul_nop_stall", stall, 0);
        chk("mul_nop_flag", flag_result_execute, 0);
        chk("mul_nop_res", comb_result_execute, 32'd0);
        tick();
        chk("mul_nop_wbv", reset_wb, 1);
        chk("mul_nop_we", write_en, 0);
`endif

        // Asynchronous reset mid-stream
        drv(1'b1, ADD, 3'd1, 32'd1, 32'd2, 3'd0, 3'd0);
        tick();
        drv(1'b1, ADD, 3'd2, 32'd3, 32'd4, 3'd0, 3'd0);
        tick();
        chk("pre_rst_ex", reset_execute, 1);
        chk("pre_rst_we", write_en, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ex", reset_execute, 0);
        chk("arst_wbv", reset_wb, 0);
        chk("arst_we", write_en, 0);
        chk("arst_flag", flag_result_execute, 0);
        chk("arst_comb", comb_result_execute, 0);
        chk("arst_res_wb", result_wb, 0);
        chk("arst_dest", {dest_wb, dest_execute}, 0);
        chk("arst_mem", {read, write, addr}, 0);
        chk("arst_dout", data_out, 0);
        chk("arst_stall", stall, 0);
        idle();
        #2;
        reset = 1'b1;
        tick();
        chk("post_rst_we1", write_en, 0);
        chk("post_rst_ex", reset_execute, 0);
        tick();
        chk("post_rst_we2", write_en, 0);
        drv(1'b1, ADD, 3'd5, 32'd10, 32'd20, 3'd0, 3'd0);
        tick();
        idle();
        tick();
        chk("recover_we", write_en, 1);
        chk("recover_res", result_wb, 32'd30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
